// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the alignment rule used to flag misaligned accesses.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Only halfword and word accesses carry alignment constraints.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return (addr_lo != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: store lane enables/data placement and load
// extraction with zero or sign extension. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  lane_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // lane_en[i] selects byte offset i, which lives in rword/wword[31-8i -: 8].
    always_comb begin
        lane_en = 4'b0000;
        wword   = 32'h0;
        case (size)
            SIZE_BYTE: begin
                lane_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                lane_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                lane_en = 4'b1111;
                wword   = wdata;
            end
            default: begin
                lane_en = 4'b0000;
                wword   = 32'h0;
            end
        endcase
    end

    always_comb begin
        rbyte = 8'h0;
        case (addr_lo)
            2'd0:    rbyte = rword[31:24];
            2'd1:    rbyte = rword[23:16];
            2'd2:    rbyte = rword[15:8];
            default: rbyte = rword[7:0];
        endcase
        rhalf = addr_lo[1] ? rword[15:0] : rword[31:16];
    end

    always_comb begin
        rdata = 32'h0;
        case (size)
            SIZE_BYTE: rdata = {{24{sign_ext & rbyte[7]}}, rbyte};
            SIZE_HALF: rdata = {{16{sign_ext & rhalf[15]}}, rhalf};
            SIZE_WORD: rdata = rword;
            default:   rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready,
// big-endian byte array, registered response held until the requester takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; request fields are sampled only then, and rsp_* hold steady
    // from rsp_valid rising until the edge where rsp_ready is seen high.

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_STATES must be in 0..15");
    end
    if (ADDR_W < 2 || ADDR_W > 31) begin : g_bad_addr
        $error("dmem_responder: ADDR_W must be in 2..31");
    end

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        accept;
    logic        enter_resp;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_signed;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;

    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rword;
    logic [3:0]        lane_en;
    logic [31:0]       wword;
    logic [31:0]       load_data;
    logic              wr_en;

    logic [7:0] mem [DEPTH];

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // With no wait states the access happens on the accept edge itself, so the
    // live request fields are used whenever the FSM is still in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we     = req_we;
            acc_size   = req_size;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_we     = lat_we;
            acc_size   = lat_size;
            acc_signed = lat_signed;
            acc_addr   = lat_addr;
            acc_wdata  = lat_wdata;
        end
    end

    assign acc_err  = misaligned(acc_size, acc_addr[1:0])
                    | (acc_size == SIZE_RSVD)
                    | (acc_addr[31:ADDR_W] != '0);
    assign word_idx = acc_addr[ADDR_W-1:2];
    assign rword    = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                       mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

    dmem_lane_align u_lane_align (
        .size     (acc_size),
        .sign_ext (acc_signed),
        .addr_lo  (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .rword    (rword),
        .lane_en  (lane_en),
        .wword    (wword),
        .rdata    (load_data)
    );

    // Gated by reset so nothing is written while reset holds the FSM in IDLE.
    assign wr_en = enter_resp & acc_we & ~acc_err & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_size   <= SIZE_BYTE;
            lat_signed <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we     <= req_we;
                lat_size   <= req_size;
                lat_signed <= req_signed;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                cnt        <= WS_LOAD;
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? 32'h0 : load_data;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l]) begin
                    mem[{word_idx, 2'(l)}] <= wword[31-8*l -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a byte-array reference model, on a 1-wait-state and a 0-wait-state instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  reset_v     = 2'b00;
    logic [1:0]  req_valid_v = 2'b00;
    logic [1:0]  rsp_ready_v = 2'b00;
    logic        req_we      = 1'b0;
    logic [1:0]  req_size    = 2'b00;
    logic        req_signed  = 1'b0;
    logic [31:0] req_addr    = 32'h0;
    logic [31:0] req_wdata   = 32'h0;

    logic        rdy0, rdy1, vld0, vld1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  st0, st1;

    logic        sel = 1'b0;
    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_state;

    assign cur_ready = sel ? rdy1   : rdy0;
    assign cur_valid = sel ? vld1   : vld0;
    assign cur_err   = sel ? err1   : err0;
    assign cur_rdata = sel ? rdata1 : rdata0;
    assign cur_state = sel ? st1    : st0;

    dmem_responder #(.ADDR_W(9), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset_v[0]), .req_valid(req_valid_v[0]), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld0),
        .rsp_ready(rsp_ready_v[0]), .rsp_rdata(rdata0), .rsp_err(err0), .fsm_state(st0)
    );

    dmem_responder #(.ADDR_W(9), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset_v[1]), .req_valid(req_valid_v[1]), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld1),
        .rsp_ready(rsp_ready_v[1]), .rsp_rdata(rdata1), .rsp_err(err1), .fsm_state(st1)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0]  mdl [2][512];
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: memory as a flat byte list, access = nb consecutive bytes MSB first.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic o_err, output logic [31:0] o_rdata);
        int nb;
        longint unsigned v;
        nb      = 1 << size;
        o_err   = (size == 2'd3) || (addr >= 32'd512) || (addr % nb != 0);
        o_rdata = 32'h0;
        if (o_err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mdl[sel][addr + i] = 8'(wdata >> (8 * (nb - 1 - i)));
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mdl[sel][addr + i]);
            if (sgn && nb < 4 && v[8 * nb - 1]) v = v | (~64'd0 << (8 * nb));
            o_rdata = v[31:0];
        end
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int n = 0;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid_v[sel] = 1'b1;
        while (cur_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk({tag, " req_ready"}, {31'b0, cur_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_v[sel] = 1'b0;
        // Scramble request fields: the responder must work from what it latched.
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (cur_valid !== 1'b1 && n < 40);
        chk({tag, " rsp_valid"}, {31'b0, cur_valid}, 32'd1);
        chk({tag, " latency"}, 32'(n), sel ? 32'd1 : 32'd2);
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_v[sel] = 1'b0;
        @(negedge clk);
        chk({tag, " idle req_ready"}, {31'b0, cur_ready}, 32'd1);
        chk({tag, " idle rsp_valid"}, {31'b0, cur_valid}, 32'd0);
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic        x_err;
        logic [31:0] x_rdata;
        model(we, size, sgn, addr, wdata, x_err, x_rdata);
        send(we, size, sgn, addr, wdata, tag);
        wait_rsp(tag);
        chk({tag, " err"}, {31'b0, cur_err}, {31'b0, x_err});
        chk({tag, " rdata"}, cur_rdata, x_rdata);
        last_rdata = cur_rdata;
        last_err   = cur_err;
        take_rsp(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        // Reset and release
        repeat (3) @(negedge clk);
        chk("in reset req_ready", {31'b0, rdy0}, 32'd1);
        chk("in reset rsp_valid", {31'b0, vld0}, 32'd0);
        reset_v = 2'b11;
        @(negedge clk);
        chk("rst req_ready", {31'b0, cur_ready}, 32'd1);
        chk("rst rsp_valid", {31'b0, cur_valid}, 32'd0);
        chk("rst rsp_rdata", cur_rdata, 32'h0);
        chk("rst rsp_err", {31'b0, cur_err}, 32'd0);
        chk("rst state", {30'b0, cur_state}, {30'b0, ST_IDLE});

        // Word store/load
        xact(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10");
        xact(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_w10");
        chk("ld_w10 const", last_rdata, 32'hDEADBEEF);

        // Sub-word loads with extension
        xact(1'b0, SIZE_BYTE, 1'b1, 32'h10, 32'h0, "ld_bs10");
        chk("ld_bs10 const", last_rdata, 32'hFFFFFFDE);
        xact(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, "ld_bu13");
        chk("ld_bu13 const", last_rdata, 32'h000000EF);
        xact(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'h0, "ld_hs12");
        chk("ld_hs12 const", last_rdata, 32'hFFFFBEEF);
        xact(1'b0, SIZE_WORD, 1'b1, 32'h10, 32'h0, "ld_ws10");
        chk("ld_ws10 const", last_rdata, 32'hDEADBEEF);

        // Byte store leaves the other lanes alone
        xact(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'hFFFFFF5A, "st_b11");
        xact(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_w10b");
        chk("ld_w10b const", last_rdata, 32'hDE5ABEEF);

        // Error cases
        xact(1'b1, SIZE_HALF, 1'b0, 32'h13, 32'h0000CAFE, "st_h13_mis");
        chk("st_h13_mis const err", {31'b0, last_err}, 32'd1);
        xact(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_w10c");
        chk("ld_w10c const", last_rdata, 32'hDE5ABEEF);
        xact(1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0, "ld_w200_oor");
        chk("ld_w200_oor const err", {31'b0, last_err}, 32'd1);
        xact(1'b1, SIZE_RSVD, 1'b0, 32'h10, 32'h01234567, "st_rsvd");
        xact(1'b0, SIZE_WORD, 1'b0, 32'h12, 32'h0, "ld_w12_mis");
        xact(1'b1, SIZE_BYTE, 1'b0, 32'h8000_0011, 32'h77, "st_b_hi_oor");
        xact(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_w10d");

        // Held response; a pending request must not slip in
        model(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, e_err, e_rdata);
        send(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "hold");
        wait_rsp("hold");
        req_we = 1'b1; req_size = SIZE_WORD; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;
        req_valid_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold rsp_valid", {31'b0, cur_valid}, 32'd1);
            chk("hold rsp_rdata", cur_rdata, e_rdata);
            chk("hold req_ready", {31'b0, cur_ready}, 32'd0);
        end
        rsp_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_v[0] = 1'b0;
        req_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("hold release req_ready", {31'b0, cur_ready}, 32'd1);
        chk("hold release rsp_valid", {31'b0, cur_valid}, 32'd0);
        xact(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_after_hold");

        // Reset while BUSY abandons the store
        xact(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'hCAFEF00D, "st_w20");
        send(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h11223344, "abort_busy");
        chk("abort_busy state", {30'b0, cur_state}, {30'b0, ST_BUSY});
        reset_v[0] = 1'b0;
        #2;
        chk("abort_busy in reset state", {30'b0, cur_state}, {30'b0, ST_IDLE});
        reset_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_busy no rsp", {31'b0, cur_valid}, 32'd0);
        end
        xact(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, "ld_w20");
        chk("ld_w20 const", last_rdata, 32'hCAFEF00D);

        // Randomized traffic in a pre-filled window plus out-of-range addresses
        for (int a = 32'h100; a < 32'h140; a += 4)
            xact(1'b1, SIZE_WORD, 1'b0, 32'(a), $urandom, "fill");
        for (int i = 0; i < 60; i++) begin
            r_size = ($urandom_range(0, 9) == 0) ? SIZE_RSVD : 2'($urandom_range(0, 2));
            r_addr = ($urandom_range(0, 7) == 0) ? 32'h200 + $urandom_range(0, 4095)
                                                 : 32'h100 + $urandom_range(0, 63);
            xact(1'($urandom), r_size, 1'($urandom), r_addr, $urandom, "rand");
        end

        // Zero-wait-state instance
        sel = 1'b1;
        @(negedge clk);
        xact(1'b1, SIZE_WORD, 1'b0, 32'h24, 32'h80FF7F01, "z_st_w24");
        xact(1'b0, SIZE_HALF, 1'b1, 32'h24, 32'h0, "z_ld_hs24");
        chk("z_ld_hs24 const", last_rdata, 32'hFFFF80FF);
        xact(1'b0, SIZE_BYTE, 1'b1, 32'h26, 32'h0, "z_ld_bs26");
        chk("z_ld_bs26 const", last_rdata, 32'h0000007F);

        // Reset while in RESP: the store already landed
        model(1'b1, SIZE_WORD, 1'b0, 32'h24, 32'h55667788, e_err, e_rdata);
        send(1'b1, SIZE_WORD, 1'b0, 32'h24, 32'h55667788, "z_abort_resp");
        chk("z_abort_resp state", {30'b0, cur_state}, {30'b0, ST_RESP});
        reset_v[1] = 1'b0;
        #2;
        chk("z_abort_resp in reset rsp_valid", {31'b0, cur_valid}, 32'd0);
        reset_v[1] = 1'b1;
        @(negedge clk);
        chk("z_abort_resp no rsp", {31'b0, cur_valid}, 32'd0);
        xact(1'b0, SIZE_WORD, 1'b0, 32'h24, 32'h0, "z_ld_w24");
        chk("z_ld_w24 const", last_rdata, 32'h55667788);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
